frame_rd_buf: RTL and testbench



---
 rtl/frame_buf_pkg.sv | 43 ++++
 rtl/rd_line_fifo.sv | 70 +++++++
 rtl/frame_rd_buf.sv | 195 +++++++++++++++++++
 tb/tb_frame_rd_buf.sv | 526 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buf_pkg.sv
// Shared defaults, geometry helpers and request FSM states for the frame read path.
// Imported by rd_line_fifo and frame_rd_buf.
package frame_buf_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 28;
  localparam int unsigned DEF_ADDR_OFFSET = 0;
  localparam int unsigned DEF_H_NUM       = 1280;
  localparam int unsigned DEF_V_NUM       = 720;
  localparam int unsigned DEF_DQ_WIDTH    = 32;
  localparam int unsigned DEF_LEN_WIDTH   = 32;
  localparam int unsigned DEF_PIX_WIDTH   = 16;
  localparam int unsigned DEF_FIFO_AW     = 8;

  function automatic int unsigned calc_ppw(
    input int unsigned dq_w,
    input int unsigned pix_w
  );
    return (8 * dq_w) / pix_w;
  endfunction

  function automatic int unsigned calc_wpl(
    input int unsigned h_num,
    input int unsigned dq_w,
    input int unsigned pix_w
  );
    return h_num / calc_ppw(dq_w, pix_w);
  endfunction

  function automatic int unsigned calc_stride(
    input int unsigned h_num,
    input int unsigned dq_w,
    input int unsigned pix_w
  );
    return (h_num * pix_w) / dq_w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } rd_state_e;

endpackage

// File: rtl/rd_line_fifo.sv
// Synchronous show-ahead line FIFO: rd_data_o is the head word whenever not empty.
// Ports: clk_i, rst_i, flush_i, wr_en_i/wr_data_i, rd_en_i/rd_data_o, count_o, empty_o.
module rd_line_fifo
  import frame_buf_pkg::*;
#(
  parameter int DW = 256,
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic [AW:0]   count_o,
  output logic          empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full;
  logic          do_wr;
  logic          do_rd;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_wr   = wr_en_i & ~full;
  assign do_rd   = rd_en_i & ~empty_o;

  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_wr) wptr_d = wptr_q + 1'b1;
      if (do_rd) rptr_d = rptr_q + 1'b1;
      if (do_wr && !do_rd) cnt_d = cnt_q + 1'b1;
      if (!do_wr && do_rd) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr && !flush_i) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/frame_rd_buf.sv
// Frame read buffer: requests one line per burst from DDR, buffers words, unpacks pixels.
// Ports: ddr_clk/ddr_rst, init_done, rd_fsync, rd_en -> vout_*, underflow, ddr_r* request/data.
module frame_rd_buf
  import frame_buf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned ADDR_OFFSET = DEF_ADDR_OFFSET,
  parameter int unsigned H_NUM       = DEF_H_NUM,
  parameter int unsigned V_NUM       = DEF_V_NUM,
  parameter int unsigned DQ_WIDTH    = DEF_DQ_WIDTH,
  parameter int unsigned LEN_WIDTH   = DEF_LEN_WIDTH,
  parameter int unsigned PIX_WIDTH   = DEF_PIX_WIDTH,
  parameter int unsigned FIFO_AW     = DEF_FIFO_AW
) (
  input  logic                    ddr_clk,
  input  logic                    ddr_rst,
  input  logic                    init_done,
  input  logic                    rd_fsync,
  input  logic                    rd_en,
  output logic                    vout_de,
  output logic [PIX_WIDTH-1:0]    vout_data,
  output logic                    underflow,
  output logic                    ddr_rreq,
  output logic [ADDR_WIDTH-1:0]   ddr_raddr,
  output logic [LEN_WIDTH-1:0]    ddr_rd_len,
  input  logic                    ddr_rrdy,
  input  logic                    ddr_rdone,
  input  logic [8*DQ_WIDTH-1:0]   ddr_rdata,
  input  logic                    ddr_rdata_en
);

  localparam int WW     = 8 * DQ_WIDTH;
  localparam int PPW    = calc_ppw(DQ_WIDTH, PIX_WIDTH);
  localparam int WPL    = calc_wpl(H_NUM, DQ_WIDTH, PIX_WIDTH);
  localparam int STRIDE = calc_stride(H_NUM, DQ_WIDTH, PIX_WIDTH);
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int IDXW   = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int LCW    = $clog2(V_NUM + 1);

  // A new line fits only if the FIFO holds at most DEPTH-WPL words.
  localparam logic [FIFO_AW:0] CNT_LIM = (FIFO_AW+1)'(DEPTH - WPL);

  rd_state_e             state_q, state_d;
  logic [LCW-1:0]        line_q, line_d;
  logic                  discard_q, discard_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [IDXW-1:0]       pix_idx_q, pix_idx_d;
  logic                  de_q, de_d;
  logic [PIX_WIDTH-1:0]  data_q, data_d;
  logic                  uf_q, uf_d;

  logic [WW-1:0]         fifo_rdata;
  logic [FIFO_AW:0]      fifo_cnt;
  logic                  fifo_empty;
  logic                  fifo_wr;
  logic                  fifo_pop;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic [PIX_WIDTH-1:0]  pix_lanes [PPW];
  logic [PIX_WIDTH-1:0]  pix_sel;

  // Words of an abandoned burst, and anything arriving with rd_fsync, are dropped.
  assign fifo_wr = ddr_rdata_en & ~discard_q & ~rd_fsync;

  rd_line_fifo #(
    .DW (WW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk_i     (ddr_clk),
    .rst_i     (ddr_rst),
    .flush_i   (rd_fsync),
    .wr_en_i   (fifo_wr),
    .wr_data_i (ddr_rdata),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rdata),
    .count_o   (fifo_cnt),
    .empty_o   (fifo_empty)
  );

  assign line_addr = ADDR_WIDTH'(ADDR_OFFSET)
                   + ADDR_WIDTH'(line_q) * ADDR_WIDTH'(STRIDE);

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    discard_d = discard_q;
    raddr_d   = raddr_q;
    len_d     = len_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_fsync) begin
          line_d = '0;
        end else if (init_done && (line_q < LCW'(V_NUM))
                     && (fifo_cnt <= CNT_LIM)) begin
          state_d = ST_REQ;
          raddr_d = line_addr;
          len_d   = LEN_WIDTH'(WPL);
        end
      end
      ST_REQ: begin
        if (rd_fsync) begin
          line_d = '0;
          // An accepted burst still delivers data; drain it before idling.
          if (ddr_rrdy) begin
            state_d   = ST_WAIT;
            discard_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (ddr_rrdy) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rd_fsync) begin
          line_d = '0;
        end else if (ddr_rdone && !discard_q) begin
          line_d = line_q + 1'b1;
        end
        if (ddr_rdone) begin
          state_d   = ST_IDLE;
          discard_d = 1'b0;
        end else if (rd_fsync) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < PPW; k++) begin
      pix_lanes[k] = fifo_rdata[k*PIX_WIDTH +: PIX_WIDTH];
    end
  end

  assign pix_sel = pix_lanes[pix_idx_q];

  always_comb begin
    pix_idx_d = pix_idx_q;
    de_d      = 1'b0;
    data_d    = data_q;
    uf_d      = uf_q;
    fifo_pop  = 1'b0;
    if (rd_fsync) begin
      pix_idx_d = '0;
    end else if (rd_en) begin
      de_d = 1'b1;
      if (fifo_empty) begin
        data_d = '0;
        uf_d   = 1'b1;
      end else begin
        data_d = pix_sel;
        if (pix_idx_q == IDXW'(PPW - 1)) begin
          pix_idx_d = '0;
          fifo_pop  = 1'b1;
        end else begin
          pix_idx_d = pix_idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      state_q   <= ST_IDLE;
      line_q    <= '0;
      discard_q <= 1'b0;
      raddr_q   <= '0;
      len_q     <= '0;
      pix_idx_q <= '0;
      de_q      <= 1'b0;
      data_q    <= '0;
      uf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      discard_q <= discard_d;
      raddr_q   <= raddr_d;
      len_q     <= len_d;
      pix_idx_q <= pix_idx_d;
      de_q      <= de_d;
      data_q    <= data_d;
      uf_q      <= uf_d;
    end
  end

  assign ddr_rreq   = (state_q == ST_REQ);
  assign ddr_raddr  = raddr_q;
  assign ddr_rd_len = len_q;
  assign vout_de    = de_q;
  assign vout_data  = data_q;
  assign underflow  = uf_q;

endmodule

// File: tb/tb_frame_rd_buf.sv
// Self-checking bench for frame_rd_buf with a small line/frame geometry.
// A pixel-queue model predicts the unpacked stream; a scripted controller answers requests.
module tb_frame_rd_buf;

  localparam int AW     = 28;
  localparam int LW     = 32;
  localparam int HN     = 32;
  localparam int VN     = 4;
  localparam int DQ     = 32;
  localparam int PW     = 16;
  localparam int FAW    = 3;
  localparam int WW     = 8 * DQ;
  localparam int PPW    = WW / PW;
  localparam int WPL    = HN / PPW;
  localparam int STRIDE = HN * PW / DQ;

  logic          ddr_clk = 1'b0;
  logic          ddr_rst;
  logic          init_done;
  logic          rd_fsync;
  logic          rd_en;
  logic          vout_de;
  logic [PW-1:0] vout_data;
  logic          underflow;
  logic          ddr_rreq;
  logic [AW-1:0] ddr_raddr;
  logic [LW-1:0] ddr_rd_len;
  logic          ddr_rrdy;
  logic          ddr_rdone;
  logic [WW-1:0] ddr_rdata;
  logic          ddr_rdata_en;

  int tests = 0;
  int fails = 0;

  logic [PW-1:0] exp_pix [$];
  logic [PW-1:0] last_pix;

  frame_rd_buf #(
    .ADDR_WIDTH  (AW),
    .ADDR_OFFSET (0),
    .H_NUM       (HN),
    .V_NUM       (VN),
    .DQ_WIDTH    (DQ),
    .LEN_WIDTH   (LW),
    .PIX_WIDTH   (PW),
    .FIFO_AW     (FAW)
  ) dut (
    .ddr_clk      (ddr_clk),
    .ddr_rst      (ddr_rst),
    .init_done    (init_done),
    .rd_fsync     (rd_fsync),
    .rd_en        (rd_en),
    .vout_de      (vout_de),
    .vout_data    (vout_data),
    .underflow    (underflow),
    .ddr_rreq     (ddr_rreq),
    .ddr_raddr    (ddr_raddr),
    .ddr_rd_len   (ddr_rd_len),
    .ddr_rrdy     (ddr_rrdy),
    .ddr_rdone    (ddr_rdone),
    .ddr_rdata    (ddr_rdata),
    .ddr_rdata_en (ddr_rdata_en)
  );

  always #5 ddr_clk = ~ddr_clk;

  task automatic tick();
    @(posedge ddr_clk);
    #1;
  endtask

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int i = 0; i < WW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic push_word(input logic [WW-1:0] w);
    for (int k = 0; k < PPW; k++) exp_pix.push_back(w[k*PW +: PW]);
  endtask

  task automatic do_reset();
    ddr_rst      = 1'b1;
    init_done    = 1'b0;
    rd_fsync     = 1'b0;
    rd_en        = 1'b0;
    ddr_rrdy     = 1'b0;
    ddr_rdone    = 1'b0;
    ddr_rdata_en = 1'b0;
    ddr_rdata    = '0;
    tick();
    tick();
    ddr_rst = 1'b0;
    exp_pix.delete();
    last_pix = '0;
  endtask

  task automatic pulse_fsync();
    rd_fsync = 1'b1;
    tick();
    rd_fsync = 1'b0;
  endtask

  task automatic wait_req(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= bound; i++) begin
      if (ddr_rreq === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (i < bound) tick();
    end
  endtask

  // Accept the pending request, deliver two words with random gaps, then rdone.
  task automatic serve_burst(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
    logic [WW-1:0] ws [2];
    ws[0] = w0;
    ws[1] = w1;
    ddr_rrdy = 1'b1;
    tick();
    ddr_rrdy = 1'b0;
    for (int j = 0; j < WPL; j++) begin
      repeat ($urandom_range(0, 2)) tick();
      ddr_rdata_en = 1'b1;
      ddr_rdata    = ws[j];
      tick();
      ddr_rdata_en = 1'b0;
      push_word(ws[j]);
    end
    ddr_rdone = 1'b1;
    tick();
    ddr_rdone = 1'b0;
  endtask

  task automatic test_reset();
    ddr_rst      = 1'b1;
    init_done    = 1'b1;
    rd_fsync     = 1'b0;
    rd_en        = 1'b1;
    ddr_rrdy     = 1'b0;
    ddr_rdone    = 1'b0;
    ddr_rdata_en = 1'b1;
    ddr_rdata    = rand_word();
    tick();
    tick();
    tests++;
    if (ddr_rreq !== 1'b0) begin
      fails++;
      $display("FAIL reset_rreq: got %0h want 0", ddr_rreq);
    end
    tests++;
    if (ddr_raddr !== '0) begin
      fails++;
      $display("FAIL reset_raddr: got %0h want 0", ddr_raddr);
    end
    tests++;
    if (ddr_rd_len !== '0) begin
      fails++;
      $display("FAIL reset_len: got %0h want 0", ddr_rd_len);
    end
    tests++;
    if (vout_de !== 1'b0) begin
      fails++;
      $display("FAIL reset_de: got %0h want 0", vout_de);
    end
    tests++;
    if (vout_data !== '0) begin
      fails++;
      $display("FAIL reset_data: got %0h want 0", vout_data);
    end
    tests++;
    if (underflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_underflow: got %0h want 0", underflow);
    end
    init_done    = 1'b0;
    rd_en        = 1'b0;
    ddr_rdata_en = 1'b0;
    tick();
    ddr_rst = 1'b0;
  endtask

  task automatic test_requests();
    bit            ok;
    bit            extra;
    int            hold;
    logic [AW-1:0] a0;
    logic [WW-1:0] pat;
    for (int k = 0; k < PPW; k++) pat[k*PW +: PW] = PW'(k);
    do_reset();
    init_done = 1'b1;
    pulse_fsync();
    for (int line = 0; line < VN; line++) begin
      wait_req(20, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL req_timeout: line %0d got no request", line);
      end
      tests++;
      if (ddr_raddr !== AW'(line * STRIDE) || ddr_rd_len !== LW'(WPL)) begin
        fails++;
        $display("FAIL req_fields: line %0d got addr %0h len %0d want %0h %0d",
                 line, ddr_raddr, ddr_rd_len, line * STRIDE, WPL);
      end
      hold = (line == 1) ? 5 : $urandom_range(0, 3);
      a0   = ddr_raddr;
      for (int h = 0; h < hold; h++) begin
        tick();
        tests++;
        if (ddr_rreq !== 1'b1 || ddr_raddr !== a0) begin
          fails++;
          $display("FAIL req_stable: got rreq %0h addr %0h want 1 %0h",
                   ddr_rreq, ddr_raddr, a0);
        end
      end
      serve_burst((line == 0) ? pat : rand_word(), rand_word());
    end
    extra = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ddr_rreq !== 1'b0) extra = 1'b1;
    end
    tests++;
    if (extra) begin
      fails++;
      $display("FAIL frame_end: got request after %0d lines want none", VN);
    end
  endtask

  task automatic test_unpack();
    logic [PW-1:0] e;
    e = '0;
    for (int c = 0; c < 800 && exp_pix.size() > 0; c++) begin
      rd_en = (c < PPW) ? 1'b1 : 1'($urandom_range(0, 1));
      if (rd_en) e = exp_pix.pop_front();
      tick();
      tests++;
      if (rd_en) begin
        if (vout_de !== 1'b1 || vout_data !== e) begin
          fails++;
          $display("FAIL unpack_pix: got de %0h data %0h want 1 %0h",
                   vout_de, vout_data, e);
        end
        last_pix = e;
      end else if (vout_de !== 1'b0 || vout_data !== last_pix) begin
        fails++;
        $display("FAIL unpack_idle: got de %0h data %0h want 0 %0h",
                 vout_de, vout_data, last_pix);
      end
    end
    rd_en = 1'b0;
    tests++;
    if (exp_pix.size() != 0 || underflow !== 1'b0) begin
      fails++;
      $display("FAIL unpack_done: got left %0d uf %0h want 0 0",
               exp_pix.size(), underflow);
    end
  endtask

  task automatic test_fsync_wait();
    bit            ok;
    logic [PW-1:0] e;
    pulse_fsync();
    wait_req(20, ok);
    tests++;
    if (!ok || ddr_raddr !== '0) begin
      fails++;
      $display("FAIL fsync_first: got ok %0d addr %0h want 1 0", ok, ddr_raddr);
    end
    ddr_rrdy = 1'b1;
    tick();
    ddr_rrdy     = 1'b0;
    ddr_rdata_en = 1'b1;
    ddr_rdata    = rand_word();
    tick();
    ddr_rdata_en = 1'b0;
    pulse_fsync();
    tick();
    ddr_rdata_en = 1'b1;
    ddr_rdata    = rand_word();
    tick();
    ddr_rdata_en = 1'b0;
    tick();
    ddr_rdone = 1'b1;
    tick();
    ddr_rdone = 1'b0;
    wait_req(20, ok);
    tests++;
    if (!ok || ddr_raddr !== '0) begin
      fails++;
      $display("FAIL fsync_restart: got ok %0d addr %0h want 1 0", ok, ddr_raddr);
    end
    serve_burst(rand_word(), rand_word());
    rd_en = 1'b1;
    for (int i = 0; i < WPL * PPW; i++) begin
      e = exp_pix.pop_front();
      tick();
      tests++;
      if (vout_de !== 1'b1 || vout_data !== e) begin
        fails++;
        $display("FAIL fsync_stream: pix %0d got %0h want %0h", i, vout_data, e);
      end
    end
    rd_en = 1'b0;
    wait_req(20, ok);
    tests++;
    if (!ok || ddr_raddr !== AW'(STRIDE)) begin
      fails++;
      $display("FAIL fsync_next: got ok %0d addr %0h want 1 %0h",
               ok, ddr_raddr, STRIDE);
    end
  endtask

  task automatic test_underflow();
    logic [WW-1:0] w;
    logic [PW-1:0] e;
    do_reset();
    w = rand_word();
    w[WW-1 -: PW] = w[WW-1 -: PW] | PW'(1);
    ddr_rdata_en = 1'b1;
    ddr_rdata    = w;
    tick();
    ddr_rdata_en = 1'b0;
    push_word(w);
    rd_en = 1'b1;
    for (int i = 0; i < PPW; i++) begin
      e = exp_pix.pop_front();
      tick();
      tests++;
      if (vout_data !== e || underflow !== 1'b0) begin
        fails++;
        $display("FAIL uf_prefill: got %0h uf %0h want %0h 0",
                 vout_data, underflow, e);
      end
    end
    tick();
    rd_en = 1'b0;
    tests++;
    if (vout_de !== 1'b1 || vout_data !== '0 || underflow !== 1'b1) begin
      fails++;
      $display("FAIL uf_empty_pop: got de %0h data %0h uf %0h want 1 0 1",
               vout_de, vout_data, underflow);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (underflow !== 1'b1 || vout_de !== 1'b0) begin
        fails++;
        $display("FAIL uf_sticky: got uf %0h de %0h want 1 0", underflow, vout_de);
      end
    end
    do_reset();
    tests++;
    if (underflow !== 1'b0) begin
      fails++;
      $display("FAIL uf_clear: got %0h want 0", underflow);
    end
  endtask

  task automatic test_init_gate();
    bit seen;
    do_reset();
    pulse_fsync();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ddr_rreq !== 1'b0) seen = 1'b1;
      tick();
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL init_gate: got request with init_done low want none");
    end
    init_done = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (ddr_rreq === 1'b1) break;
    end
    tests++;
    if (ddr_rreq !== 1'b1 || ddr_raddr !== '0) begin
      fails++;
      $display("FAIL init_rise: got rreq %0h addr %0h want 1 0", ddr_rreq, ddr_raddr);
    end
  endtask

  task automatic test_back_to_back();
    int            lines;
    int            ctl;
    int            sent;
    int            popped;
    int            cyc;
    bit            pend;
    bit            extra;
    logic [WW-1:0] pend_w;
    logic [WW-1:0] w;
    logic [PW-1:0] e;
    do_reset();
    init_done = 1'b1;
    pulse_fsync();
    lines  = 0;
    ctl    = 0;
    sent   = 0;
    popped = 0;
    cyc    = 0;
    pend   = 1'b0;
    pend_w = '0;
    e      = '0;
    while (!(lines == VN && exp_pix.size() == 0 && !pend) && cyc < 3000) begin
      cyc++;
      if (pend) begin
        push_word(pend_w);
        pend = 1'b0;
      end
      ddr_rrdy     = 1'b0;
      ddr_rdata_en = 1'b0;
      ddr_rdone    = 1'b0;
      if (ctl != 0 && ddr_rreq !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL b2b_overlap: got request during burst want none");
      end
      if (ctl == 0) begin
        if (ddr_rreq === 1'b1) begin
          tests++;
          if (lines >= VN || ddr_raddr !== AW'(lines * STRIDE)
              || ddr_rd_len !== LW'(WPL)) begin
            fails++;
            $display("FAIL b2b_req: line %0d got addr %0h len %0d want %0h %0d",
                     lines, ddr_raddr, ddr_rd_len, lines * STRIDE, WPL);
          end
          if ($urandom_range(0, 2) == 0) begin
            ddr_rrdy = 1'b1;
            ctl      = 1;
            sent     = 0;
          end
        end
      end else if (ctl == 1) begin
        if ($urandom_range(0, 3) != 0) begin
          w            = rand_word();
          ddr_rdata_en = 1'b1;
          ddr_rdata    = w;
          pend_w       = w;
          pend         = 1'b1;
          sent++;
          if (sent == WPL) begin
            if ($urandom_range(0, 1) == 1) begin
              ddr_rdone = 1'b1;
              ctl       = 0;
              lines++;
            end else begin
              ctl = 2;
            end
          end
        end
      end else begin
        ddr_rdone = 1'b1;
        ctl       = 0;
        lines++;
      end
      rd_en = (exp_pix.size() > 0) && ($urandom_range(0, 1) == 1);
      if (rd_en) begin
        e = exp_pix.pop_front();
        popped++;
      end
      tick();
      tests++;
      if (rd_en) begin
        if (vout_de !== 1'b1 || vout_data !== e) begin
          fails++;
          $display("FAIL b2b_pix: got de %0h data %0h want 1 %0h",
                   vout_de, vout_data, e);
        end
        last_pix = e;
      end else if (vout_de !== 1'b0 || vout_data !== last_pix) begin
        fails++;
        $display("FAIL b2b_idle: got de %0h data %0h want 0 %0h",
                 vout_de, vout_data, last_pix);
      end
    end
    rd_en        = 1'b0;
    ddr_rrdy     = 1'b0;
    ddr_rdone    = 1'b0;
    ddr_rdata_en = 1'b0;
    tests++;
    if (lines != VN || popped != VN * WPL * PPW || underflow !== 1'b0) begin
      fails++;
      $display("FAIL b2b_total: got lines %0d pix %0d uf %0h want %0d %0d 0",
               lines, popped, underflow, VN, VN * WPL * PPW);
    end
    extra = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ddr_rreq !== 1'b0) extra = 1'b1;
    end
    tests++;
    if (extra) begin
      fails++;
      $display("FAIL b2b_end: got request after frame want none");
    end
  endtask

  initial begin
    ddr_rst      = 1'b1;
    init_done    = 1'b0;
    rd_fsync     = 1'b0;
    rd_en        = 1'b0;
    ddr_rrdy     = 1'b0;
    ddr_rdone    = 1'b0;
    ddr_rdata_en = 1'b0;
    ddr_rdata    = '0;
    last_pix     = '0;
    test_reset();
    test_requests();
    test_unpack();
    test_fsync_wait();
    test_underflow();
    test_init_gate();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
